// File: rtl/int_cmt_arbiter.sv
// int_cmt_arbiter
//   Shares the ROB commit write ports between the integer-block commit
//   producers (0=MISC, 1=ALU0, 2=ALU1, 3=MDU). Each cycle up to N_PORT
//   producers are granted in round-robin order into the free output slots.
//   Each granted payload appears in a registered slot one cycle later.
//
//   Optional build macro: INT_CMT_ARB_MISC_PRIO_EN
//     When defined, source 0 (MISC) is granted first whenever it is valid
//     and a slot is free. The round-robin pointer then covers only sources
//     1..N_SRC-1.
//
// Ports:
//   clk, a_rst_n   clock, asynchronous active-low reset
//   flush_i        drop held slot contents and block grants this cycle
//   src_valid_i    per-producer commit valid
//   src_data_i     per-producer payload, source i at [i*DATA_W +: DATA_W]
//   src_ready_o    per-producer grant (combinational, data-independent)
//   port_valid_o   output slot valid (straight from flops)
//   port_data_o    output slot payload
//   port_src_o     source index of each slot's payload
//   port_ready_i   ROB accepts the slot this cycle
module int_cmt_arbiter #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned N_PORT = 2,
  parameter int unsigned DATA_W = 64,
  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     a_rst_n,
  input  logic                     flush_i,
  input  logic [N_SRC-1:0]         src_valid_i,
  input  logic [N_SRC*DATA_W-1:0]  src_data_i,
  output logic [N_SRC-1:0]         src_ready_o,
  output logic [N_PORT-1:0]        port_valid_o,
  output logic [N_PORT*DATA_W-1:0] port_data_o,
  output logic [N_PORT*SRC_W-1:0]  port_src_o,
  input  logic [N_PORT-1:0]        port_ready_i
);

`ifdef INT_CMT_ARB_MISC_PRIO_EN
  localparam logic [SRC_W-1:0] RR_INIT = SRC_W'(1);
`else
  localparam logic [SRC_W-1:0] RR_INIT = '0;
`endif

  logic [DATA_W-1:0] src_data_arr [N_SRC];
  logic [DATA_W-1:0] slot_data    [N_PORT];
  logic [SRC_W-1:0]  slot_src     [N_PORT];
  logic [SRC_W-1:0]  rr_ptr;

  logic [N_PORT-1:0] slot_free;
  logic [N_PORT-1:0] slot_load;
  logic [SRC_W-1:0]  slot_sel  [N_PORT];
  logic [SRC_W-1:0]  gnt_list  [N_PORT];
  int unsigned       n_free;
  int unsigned       n_gnt;
  int unsigned       r;
  logic [SRC_W:0]    sum;
  logic [SRC_W-1:0]  idx;
  logic              rr_hit;
  logic [SRC_W-1:0]  rr_last;
  logic [SRC_W-1:0]  rr_next;

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_data_arr[i] = src_data_i[i*DATA_W +: DATA_W];
  end

  for (genvar k = 0; k < N_PORT; k++) begin : g_pack
    assign port_data_o[k*DATA_W +: DATA_W] = slot_data[k];
    assign port_src_o[k*SRC_W +: SRC_W]    = slot_src[k];
  end

  // Grant selection: build the ordered list of granted sources first, then
  // hand them out to free slots in ascending slot order.
  always_comb begin
    slot_free   = ~port_valid_o | port_ready_i;
    n_free      = 0;
    n_gnt       = 0;
    r           = 0;
    sum         = '0;
    idx         = '0;
    rr_hit      = 1'b0;
    rr_last     = '0;
    src_ready_o = '0;
    slot_load   = '0;
    for (int unsigned k = 0; k < N_PORT; k++) begin
      gnt_list[k] = '0;
      slot_sel[k] = '0;
      if (slot_free[k]) n_free++;
    end
    // No grants while in reset or flushing.
    if (!a_rst_n || flush_i) n_free = 0;

`ifdef INT_CMT_ARB_MISC_PRIO_EN
    if (src_valid_i[0] && n_free > 0) begin
      gnt_list[0]    = '0;
      n_gnt          = 1;
      src_ready_o[0] = 1'b1;
    end
    // Round-robin over sources 1..N_SRC-1 only; rr_ptr never points at 0.
    for (int unsigned off = 0; off < N_SRC - 1; off++) begin
      sum = {1'b0, rr_ptr} + (SRC_W+1)'(off);
      if (sum >= (SRC_W+1)'(N_SRC)) sum = sum - (SRC_W+1)'(N_SRC - 1);
      idx = sum[SRC_W-1:0];
      if (src_valid_i[idx] && n_gnt < n_free) begin
        gnt_list[n_gnt]  = idx;
        n_gnt++;
        src_ready_o[idx] = 1'b1;
        rr_hit           = 1'b1;
        rr_last          = idx;
      end
    end
    rr_next = (rr_last == SRC_W'(N_SRC - 1)) ? SRC_W'(1) : rr_last + SRC_W'(1);
`else
    for (int unsigned off = 0; off < N_SRC; off++) begin
      sum = {1'b0, rr_ptr} + (SRC_W+1)'(off);
      if (sum >= (SRC_W+1)'(N_SRC)) sum = sum - (SRC_W+1)'(N_SRC);
      idx = sum[SRC_W-1:0];
      if (src_valid_i[idx] && n_gnt < n_free) begin
        gnt_list[n_gnt]  = idx;
        n_gnt++;
        src_ready_o[idx] = 1'b1;
        rr_hit           = 1'b1;
        rr_last          = idx;
      end
    end
    rr_next = (rr_last == SRC_W'(N_SRC - 1)) ? '0 : rr_last + SRC_W'(1);
`endif

    for (int unsigned k = 0; k < N_PORT; k++) begin
      if (slot_free[k] && r < n_gnt) begin
        slot_load[k] = 1'b1;
        slot_sel[k]  = gnt_list[r];
        r++;
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      port_valid_o <= '0;
      rr_ptr       <= RR_INIT;
      for (int unsigned k = 0; k < N_PORT; k++) begin
        slot_data[k] <= '0;
        slot_src[k]  <= '0;
      end
    end else if (flush_i) begin
      port_valid_o <= '0;
      rr_ptr       <= RR_INIT;
    end else begin
      for (int unsigned k = 0; k < N_PORT; k++) begin
        if (slot_load[k]) begin
          // Drain and refill in the same cycle: the new payload overwrites.
          port_valid_o[k] <= 1'b1;
          slot_data[k]    <= src_data_arr[slot_sel[k]];
          slot_src[k]     <= slot_sel[k];
        end else if (slot_free[k]) begin
          port_valid_o[k] <= 1'b0;
        end
      end
      if (rr_hit) rr_ptr <= rr_next;
    end
  end

endmodule

// File: doc/int_cmt_arbiter.md
Name: int_cmt_arbiter

Overview:
- Shares the ROB commit write ports between the integer-block commit producers: MISC, ALU0, ALU1 and MDU.
- Sits between the integer block's per-pipe commit outputs and the ROB write ports.
- Grants up to N_PORT producers per cycle using round-robin priority.
- Drives each port from a registered output slot with valid/ready back-pressure.

Parameters:
N_SRC, 4, number of commit producers (index 0=MISC, 1=ALU0, 2=ALU1, 3=MDU)
N_PORT, 2, number of ROB commit write ports
DATA_W, 64, commit payload width in bits (opaque to this block)

Ports:
clk  input  1  clock
a_rst_n  input  1  asynchronous reset, active low
flush_i  input  1  pipeline flush; discards held and incoming commits
src_valid_i  input  N_SRC  producer commit valid
src_data_i  input  N_SRC*DATA_W  producer payloads, source i at bits [i*DATA_W +: DATA_W]
src_ready_o  output  N_SRC  producer grant; the transfer happens when valid && ready
port_valid_o  output  N_PORT  output slot valid
port_data_o  output  N_PORT*DATA_W  output slot payload
port_src_o  output  N_PORT*$clog2(N_SRC)  source index of the slot's payload
port_ready_i  input  N_PORT  ROB accepts the slot this cycle

Behaviour:
- Reset (a_rst_n low, asynchronous): port_valid_o=0, port_data_o=0, port_src_o=0, rr_ptr=0. src_ready_o is combinational and reads 0 while in reset.
- Slot k is free when !port_valid_o[k] || port_ready_i[k]. F = number of free slots (0..N_PORT).
- Grant:
  - Scan sources circularly starting at rr_ptr.
  - Grant the first min(F, number of valid sources) valid sources.
  - The j-th granted source (in scan order) maps to the j-th free slot in ascending slot index.
  - src_ready_o[i]=1 only for granted i.
  - src_ready_o is combinational from src_valid_i, port state, port_ready_i and rr_ptr. It must not depend on src_data_i.
  - src_ready_o is never asserted for a source whose valid is low.
- Latency: exactly 1 cycle. A payload granted in cycle t appears on port_valid_o/port_data_o in cycle t+1.
- Slot update at posedge:
  - Slot granted this cycle: load the payload and source index; valid=1.
  - Slot not granted but free (drained): valid=0; data and src hold their old values.
  - Slot occupied and not ready: hold all fields unchanged.
- rr_ptr:
  - If at least one grant: rr_ptr <= (last granted index + 1) mod N_SRC.
  - Otherwise rr_ptr is unchanged.
  - Wrap: a grant of source N_SRC-1 sets rr_ptr to 0.
- Fairness: with all sources valid and all ports draining every cycle, each source is granted at least once every ceil(N_SRC/N_PORT) cycles (2 cycles at the defaults).
- Full: F=0 gives src_ready_o=0 everywhere; producers hold their commits.
- Empty: no valid sources means no grant; drained slots clear.
- Simultaneous drain and grant in the same slot and cycle is legal. There is no bubble: the new payload overwrites the slot.
- Flush:
  - During a cycle with flush_i=1, src_ready_o=0.
  - At the next edge all port_valid_o clear and rr_ptr is set to 0.
  - port_ready_i is ignored during flush (the held entries are discarded).
- Reset asserted mid-operation discards all slot contents immediately. Producers must re-present after reset.
- No combinational path from port_data_o to any output. port_valid_o comes directly from flops.

Optional Feature:
INT_CMT_ARB_MISC_PRIO_EN
- Defined:
  - Source 0 (MISC) is always granted first whenever it is valid and F>0.
  - The remaining free slots go round-robin among sources 1..N_SRC-1.
  - rr_ptr advances only over the grants to sources 1..N_SRC-1 and never points at 0. Its reset value and post-flush value are 1.
  - Purpose: serialising branch/CSR results commit with minimum delay.
- Undefined: source 0 takes part in plain round-robin exactly as described above.

Test Plan:
- Reset, then all src_valid_i=4'b1111 with port_ready_i=2'b11 held. Required grants: cycle0 {0,1}, cycle1 {2,3}, cycle2 {0,1}. port_src_o in cycle1 = {slot0:0, slot1:1}.
- Slot 0 valid with port_ready_i=2'b00, slot 1 empty, src_valid_i=4'b0110, rr_ptr=0. Required: only source 1 is granted into slot 1, slot 0 holds its data, rr_ptr becomes 2.
- Both slots full, port_ready_i=0 for 5 cycles. Required: src_ready_o=0 throughout and the outputs stable. Then port_ready_i=2'b11 with sources 2 and 3 valid: both are granted in the same cycle and appear at t+1.
- rr_ptr=3 with src_valid_i=4'b1001. Required: grant order is source 3 into slot0, then source 0 into slot1; rr_ptr wraps to 1.
- flush_i=1 with both slots valid and src_valid_i=4'b1111. Required: src_ready_o=0 that cycle, port_valid_o=0 in the next cycle, rr_ptr=0.
- With INT_CMT_ARB_MISC_PRIO_EN defined and all sources valid, one free slot per cycle. Required: source 0 is granted every cycle it is valid. Once source 0 deasserts, sources 1, 2, 3 are granted in rotation.
